// File: rtl/dram_copy_engine_pkg.sv
// Shared types and default widths for the DRAM block-copy engine.
// Optional fill path is enabled by defining FILL_MODE_EN.
package dram_copy_engine_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Engine is busy in every state except IDLE.
    function automatic logic state_busy(input state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/dram_copy_engine_port_driver.sv
// Flop stage between the copy FSM and the DRAM port slot.
// Write data is forwarded from the registered read port only in copy write cycles.
module dram_port_driver
    import dram_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_pass,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in
);

    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              pass_r;

    // Register the requests for the cycle that is about to start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r   <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
            pass_r <= 1'b0;
        end else begin
            we_r   <= req_we;
            addr_r <= req_addr;
            data_r <= req_data;
            pass_r <= req_pass;
        end
    end

    // Read data only exists in the write cycle itself, so the copy path
    // selects it with a flopped select instead of re-registering it.
    assign mem_write_en = we_r;
    assign mem_addr     = addr_r;
    assign mem_data_in  = pass_r ? mem_data_out : data_r;

endmodule

// File: rtl/dram_copy_engine.sv
// Block-copy master for one DRAM port slot: reads src+i, writes dst+i, ascending.
// Define FILL_MODE_EN to add the fill/fill_value ports and the 1-cycle/word fill path.
module dram_copy_engine
    import dram_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef FILL_MODE_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  words_done_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;
    logic              last_s;
    logic              fill_in_s;
    logic              fill_act_s;
    logic              fill_nxt_s;
    logic [DATA_W-1:0] fill_val_nxt_s;
    logic [LEN_W-1:0]  idx_nxt_s;
    logic [ADDR_W-1:0] base_src_s;
    logic [ADDR_W-1:0] base_dst_s;
    logic              req_we_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [DATA_W-1:0] req_data_s;
    logic              req_pass_s;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign last_s   = ((words_done_r + LEN_W'(1)) == len_r);

`ifdef FILL_MODE_EN
    logic              fill_r;
    logic [DATA_W-1:0] fill_value_r;

    // Fill command fields are captured with the rest of the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_r       <= 1'b0;
            fill_value_r <= '0;
        end else if (accept_s) begin
            fill_r       <= fill;
            fill_value_r <= fill_value;
        end else begin
            fill_r       <= fill_r;
            fill_value_r <= fill_value_r;
        end
    end

    assign fill_in_s      = fill;
    assign fill_act_s     = fill_r;
    assign fill_val_nxt_s = (state_r == ST_IDLE) ? fill_value : fill_value_r;
`else
    assign fill_in_s      = 1'b0;
    assign fill_act_s     = 1'b0;
    assign fill_val_nxt_s = '0;
`endif

    assign fill_nxt_s = (state_r == ST_IDLE) ? fill_in_s : fill_act_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == LEN_W'(0)) begin
                        next_state_s = ST_DONE;
                    end else if (fill_in_s) begin
                        next_state_s = ST_WR;
                    end else begin
                        next_state_s = ST_RD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD:   next_state_s = ST_WR;
            ST_WR: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else if (fill_act_s) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RD;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Requests are computed for the next state so the port flops line up with it;
    // on the accepting edge the command comes straight from the inputs.
    always_comb begin
        idx_nxt_s  = (state_r == ST_IDLE) ? LEN_W'(0) :
                     (state_r == ST_WR)   ? (words_done_r + LEN_W'(1)) : words_done_r;
        base_src_s = (state_r == ST_IDLE) ? src_addr : src_r;
        base_dst_s = (state_r == ST_IDLE) ? dst_addr : dst_r;
        req_we_s   = 1'b0;
        req_addr_s = mem_addr;
        req_data_s = '0;
        req_pass_s = 1'b0;
        case (next_state_s)
            ST_RD: begin
                req_addr_s = base_src_s + ADDR_W'(idx_nxt_s);
            end
            ST_WR: begin
                req_we_s   = 1'b1;
                req_addr_s = base_dst_s + ADDR_W'(idx_nxt_s);
                if (fill_nxt_s) begin
                    req_data_s = fill_val_nxt_s;
                end else begin
                    req_pass_s = 1'b1;
                end
            end
            default: begin
                req_we_s = 1'b0;
            end
        endcase
    end

    // Command capture and progress counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r        <= '0;
            dst_r        <= '0;
            len_r        <= '0;
            words_done_r <= '0;
        end else if (accept_s) begin
            src_r        <= src_addr;
            dst_r        <= dst_addr;
            len_r        <= len;
            words_done_r <= '0;
        end else if (state_r == ST_WR) begin
            words_done_r <= words_done_r + LEN_W'(1);
        end else begin
            words_done_r <= words_done_r;
        end
    end

    // Status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= state_busy(next_state_s);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign words_done = words_done_r;

    dram_port_driver #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk          (clk),
        .rst          (rst),
        .req_we       (req_we_s),
        .req_addr     (req_addr_s),
        .req_data     (req_data_s),
        .req_pass     (req_pass_s),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in)
    );

endmodule

// File: tb/tb_dram_copy_engine.sv
// Directed bench for dram_copy_engine on DRAM port slot 0 (FILL_MODE_EN adds the fill test).
module tb_dram_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr, len;
    logic        busy, done;
    logic [15:0] words_done;
    logic        mem_write_en;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
`ifdef FILL_MODE_EN
    logic        fill;
    logic [15:0] fill_value;
`endif

    logic [15:0] ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_copy_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
`ifdef FILL_MODE_EN
        .fill         (fill),
        .fill_value   (fill_value),
`endif
        .busy         (busy),
        .done         (done),
        .words_done   (words_done),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // DRAM port slot 0 plus a bench-only preload path.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_write_en) ram[mem_addr] <= mem_data_in;
        else mem_data_out <= ram[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one command; cycle 0 is the accepting edge.
    task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           output int dc, output int wc, output int nd, output int ba);
        dc = -1; wc = 0; nd = 0; ba = -1;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (mem_write_en) wc++;
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (dc >= 0 && c == dc + 1) ba = int'(busy);
            if (dc >= 0 && c >= dc + 2) break;
        end
    endtask

    typedef struct {
        logic [15:0]      src, dst, len;
        int               npre;
        logic [3:0][15:0] pa, pd;
        int               nexp;
        logic [3:0][15:0] ex;
        int               dcyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int dc, wc, nd, ba;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef FILL_MODE_EN
        fill = 1'b0; fill_value = '0;
`endif
        vecs[0] = '{16'h0000, 16'd100, 16'd4, 4, {16'd3, 16'd2, 16'd1, 16'd0},
                    {16'd4, 16'd2, 16'd3, 16'd8}, 4, {16'd4, 16'd2, 16'd3, 16'd8}, 9};
        vecs[1] = '{16'h0005, 16'd300, 16'd0, 0, '0, '0, 0, '0, 1};
        vecs[2] = '{16'hFFFE, 16'd10, 16'd3, 3, {16'd0, 16'h0000, 16'hFFFF, 16'hFFFE},
                    {16'd0, 16'd7, 16'd6, 16'd5}, 3, {16'd0, 16'd7, 16'd6, 16'd5}, 7};
        vecs[3] = '{16'd20, 16'd21, 16'd3, 1, {16'd0, 16'd0, 16'd0, 16'd20},
                    {16'd0, 16'd0, 16'd0, 16'd9}, 3, {16'd0, 16'd9, 16'd9, 16'd9}, 7};
        vecs[4] = '{16'd50, 16'd60, 16'd1, 1, {16'd0, 16'd0, 16'd0, 16'd50},
                    {16'd0, 16'd0, 16'd0, 16'h1234}, 1, {16'd0, 16'd0, 16'd0, 16'h1234}, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_words", int'(words_done), 0);
        check("rst_we", int'(mem_write_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_din", int'(mem_data_in), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int p = 0; p < vecs[v].npre; p++) preload(vecs[v].pa[p], vecs[v].pd[p]);
            run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, dc, wc, nd, ba);
            check($sformatf("v%0d_done_cycle", v), dc, vecs[v].dcyc);
            check($sformatf("v%0d_done_pulses", v), nd, 1);
            check($sformatf("v%0d_busy_after", v), ba, 0);
            check($sformatf("v%0d_writes", v), wc, int'(vecs[v].len));
            check($sformatf("v%0d_words_done", v), int'(words_done), int'(vecs[v].len));
            for (int k = 0; k < vecs[v].nexp; k++)
                check($sformatf("v%0d_ram[%0d]", v, k), int'(ram[vecs[v].dst + 16'(k)]), int'(vecs[v].ex[k]));
        end

        // A second start during a busy command is dropped.
        preload(16'd30, 16'h0011);
        preload(16'd31, 16'h0022);
        preload(16'd500, 16'hDEAD);
        @(negedge clk);
        src_addr = 16'd30; dst_addr = 16'd40; len = 16'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = -1; nd = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; src_addr = 16'd0; dst_addr = 16'd500; len = 16'd1;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
        end
        check("busy_start_done_cycle", dc, 5);
        check("busy_start_pulses", nd, 1);
        check("busy_start_ram40", int'(ram[40]), 16'h0011);
        check("busy_start_ram41", int'(ram[41]), 16'h0022);
        check("busy_start_ram500", int'(ram[500]), 16'hDEAD);
        check("busy_start_words", int'(words_done), 2);

        // Reset during the write of word 2 of a 5-word copy.
        for (int k = 0; k < 5; k++) begin
            preload(16'd70 + 16'(k), 16'(k + 1));
            preload(16'd80 + 16'(k), 16'hEEEE);
        end
        @(negedge clk);
        src_addr = 16'd70; dst_addr = 16'd80; len = 16'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        check("rst_mid_we_before", int'(mem_write_en), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we", int'(mem_write_en), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_words", int'(words_done), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0; ba = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) ba++;
        end
        check("rst_mid_no_done", nd, 0);
        check("rst_mid_idle", ba, 0);
        check("rst_mid_ram80", int'(ram[80]), 1);
        check("rst_mid_ram81", int'(ram[81]), 2);
        check("rst_mid_ram82", int'(ram[82]), 16'hEEEE);

        run_cmd(16'd0, 16'd110, 16'd1, dc, wc, nd, ba);
        check("recover_done_cycle", dc, 3);
        check("recover_ram110", int'(ram[110]), 7);

`ifdef FILL_MODE_EN
        @(negedge clk);
        fill = 1'b1; fill_value = 16'hABCD;
        run_cmd(16'd0, 16'd200, 16'd3, dc, wc, nd, ba);
        fill = 1'b0;
        check("fill_done_cycle", dc, 4);
        check("fill_writes", wc, 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("fill_ram[%0d]", k), int'(ram[16'd200 + 16'(k)]), 16'hABCD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
